crc_byte_feeder: RTL and testbench
==================================

Name: crc_byte_feeder

Overview:
Upstream stage of the CRC encoder/decoder. Accepts one data word (encode) or codeword (decode) per transaction over a valid/ready handshake, and splits it MSB-first into the byte sequence the CRC stage expects. Each byte is presented with a multi-cycle strobe suitable as that stage's byte clock. The mode (encode/decode, input kind) is held stable for the whole frame so the CRC stage sees a constant selection.

Parameters:
STB_CYCLES, 2, cycles byte_stb stays high per byte (1..15)
GAP_CYCLES, 2, low cycles of byte_stb between consecutive bytes of a frame (0..15); no gap after the last byte

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
word_in  in  30  right-aligned word; only the low N bits are used (N per mode table)
word_valid  in  1  word_in/dec_or_en/select_kind valid
word_ready  out  1  feeder can accept a word this cycle
dec_or_en  in  1  0 = encode, 1 = decode
select_kind  in  2  input kind: 0, 1 or 3; 2 is illegal
byte_out  out  8  current byte
byte_stb  out  1  byte strobe; CRC stage samples byte_out on its rising edge
mode_dec_or_en  out  1  latched dec_or_en for the active frame
mode_kind  out  2  latched select_kind for the active frame
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse after the last byte strobe
err_kind  out  1  one-cycle pulse when an illegal kind is accepted

Behaviour:
- Mode table as (N bits, bytes): EN k0 = (8, 1); EN k1 = (16, 2); EN k3 = (20, 3); DEC k0 = (12, 2); DEC k1 = (24, 3); DEC k3 = (30, 4).
- Alignment: shift register sh[31:0] loads word_in[N-1:0] << (32-N). Bits above N-1 are ignored.
- Byte i = sh[31:24] after i left shifts of 8. Pad bits are zero, so a partial last byte is left-aligned: EN k3 last byte = {w[3:0],4'b0}; DEC k0 last byte = {w[3:0],4'b0}; DEC k3 last byte = {w[5:0],2'b0}.
- States: IDLE, STB, GAP, DONE.
- IDLE: word_ready=1, busy=0.
  - On word_valid with a legal kind: latch the word, mode and byte count; load byte 0 into byte_out; go to STB.
  - On word_valid with kind 2: pulse err_kind the next cycle, emit nothing, stay in IDLE.
  - word_ready is 1 in the cycle after the err_kind acceptance as well.
- STB: byte_stb=1 for exactly STB_CYCLES cycles.
  - If more bytes remain: go to GAP, or, when GAP_CYCLES=0, load the next byte and re-enter STB without dropping byte_stb.
  - If this was the last byte: go to DONE.
- GAP: byte_stb=0 for GAP_CYCLES cycles, byte_out held. On exit, load the next byte and go to STB.
- DONE: frame_done=1 for one cycle, byte_stb=0; then IDLE.
- byte_out changes only at entry to STB, never while byte_stb=1 within the same byte.
- Latency: accept on edge k → byte_stb high in cycles k+1 .. k+STB_CYCLES.
- busy=1 and word_ready=0 in STB, GAP and DONE. mode_dec_or_en and mode_kind hold from acceptance until the next acceptance.
- Input changes while busy are ignored.
- Reset (asynchronous, active-low) takes effect immediately, including mid-frame. All of the following clear to 0: byte_stb, byte_out, busy, frame_done, err_kind, mode_*, sh, counters; state returns to IDLE. word_ready=1 once rst deasserts.
- A partially sent frame is abandoned, never resumed.

Test Plan:
- EN k0, word_in=0x000000A5, STB=2, GAP=2, accepted at edge 0 → byte_out=0xA5 with byte_stb high in cycles 1–2; frame_done in cycle 3; word_ready=1 in cycle 4.
- EN k3, word_in=0x000ABCDE → bytes 0xAB, 0xCD, 0xE0. Each strobe lasts 2 cycles with 2-cycle gaps; frame_done appears exactly once; mode_kind=3 throughout.
- DEC k3, word_in=0x2ABCDEF1 → bytes 0xAA, 0xF3, 0x7B, 0xC4; busy high from cycle 1 to frame_done.
- DEC k0, word_in=0x3FFFFABC (junk upper bits) → bytes 0xAB, 0xC0 only. Repeat with GAP_CYCLES=0: byte_stb stays high continuously for 4 cycles and byte_out switches after cycle 2.
- select_kind=2 with word_valid=1 → err_kind=1 for one cycle, byte_stb never rises, busy stays 0. The next legal word (EN k1, 0x1234) → bytes 0x12, 0x34.
- Assert rst during byte 2 of a DEC k1 frame → byte_stb and busy drop to 0 in the same cycle with no frame_done. After release, EN k0 word 0x5A gives byte 0x5A normally.

Source files
------------

// File: rtl/crc_byte_feeder.sv
// crc_byte_feeder: splits a mode-sized word MSB-first into strobed bytes for the CRC stage
module crc_byte_feeder #(
  parameter int STB_CYCLES = 2,
  parameter int GAP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] word_in,
  input  logic        word_valid,
  output logic        word_ready,
  input  logic        dec_or_en,
  input  logic [1:0]  select_kind,
  output logic [7:0]  byte_out,
  output logic        byte_stb,
  output logic        mode_dec_or_en,
  output logic [1:0]  mode_kind,
  output logic        busy,
  output logic        frame_done,
  output logic        err_kind
);
  typedef enum logic [1:0] {IDLE, STB, GAP, DONE} state_t;
  localparam logic [3:0] STB_LAST = 4'(STB_CYCLES - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);
  state_t      state;
  logic [31:0] sh;
  logic [3:0]  cnt;
  logic [1:0]  left;
  logic [4:0]  n;
  logic [1:0]  nb_m1;
  logic [31:0] aligned;
  logic        accept;
  logic        legal;
  always_comb begin
    n = dec_or_en ? (select_kind == 2'd0 ? 5'd12 : select_kind == 2'd1 ? 5'd24 : 5'd30)
                  : (select_kind == 2'd0 ? 5'd8  : select_kind == 2'd1 ? 5'd16 : 5'd20);
    nb_m1 = 2'((n - 5'd1) >> 3);
    // Upper junk bits shift out past bit 31, leaving the word left-aligned with zero pad.
    aligned = {2'b0, word_in} << (6'd32 - {1'b0, n});
    legal = select_kind != 2'd2;
    accept = state == IDLE && word_valid;
  end
  assign word_ready = state == IDLE;
  assign busy       = state != IDLE;
  assign byte_stb   = state == STB;
  assign frame_done = state == DONE;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      sh             <= '0;
      cnt            <= '0;
      left           <= '0;
      byte_out       <= '0;
      mode_dec_or_en <= 1'b0;
      mode_kind      <= '0;
      err_kind       <= 1'b0;
    end else begin
      err_kind <= accept && !legal;
      case (state)
        IDLE: if (accept && legal) begin
          sh             <= aligned;
          byte_out       <= aligned[31:24];
          left           <= nb_m1;
          mode_dec_or_en <= dec_or_en;
          mode_kind      <= select_kind;
          cnt            <= '0;
          state          <= STB;
        end
        STB: if (cnt == STB_LAST) begin
          cnt <= '0;
          if (left == 2'd0) state <= DONE;
          else if (GAP_CYCLES == 0) begin
            sh       <= sh << 8;
            byte_out <= sh[23:16];
            left     <= left - 2'd1;
          end else state <= GAP;
        end else cnt <= cnt + 4'd1;
        GAP: if (cnt == GAP_LAST) begin
          cnt      <= '0;
          sh       <= sh << 8;
          byte_out <= sh[23:16];
          left     <= left - 2'd1;
          state    <= STB;
        end else cnt <= cnt + 4'd1;
        DONE: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_crc_byte_feeder.sv
// tb_crc_byte_feeder: random + directed scoreboard bench, one feeder with gaps and one without
module tb_crc_byte_feeder;
  logic        clk = 0;
  logic        rst = 0;
  logic [29:0] word_in = '0;
  logic        word_valid = 0;
  logic        dec_or_en = 0;
  logic [1:0]  select_kind = 0;
  logic        wr[2], stb[2], md[2], bz[2], fd[2], ek[2];
  logic [7:0]  bo[2];
  logic [1:0]  mk[2];
  int errors = 0, checks = 0;
  int q0[$], q1[$];
  int exp_err = 0, seen_err[2] = '{0, 0};
  bit exp_dec = 0;
  bit [1:0] exp_kind = 0;
  bit ps[2], in_frame[2];
  int run[2], gap[2], cur[2];

  always #5 clk = ~clk;

  crc_byte_feeder #(.STB_CYCLES(2), .GAP_CYCLES(2)) u0 (
    .clk(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid), .word_ready(wr[0]),
    .dec_or_en(dec_or_en), .select_kind(select_kind), .byte_out(bo[0]), .byte_stb(stb[0]),
    .mode_dec_or_en(md[0]), .mode_kind(mk[0]), .busy(bz[0]), .frame_done(fd[0]), .err_kind(ek[0]));
  crc_byte_feeder #(.STB_CYCLES(2), .GAP_CYCLES(0)) u1 (
    .clk(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid), .word_ready(wr[1]),
    .dec_or_en(dec_or_en), .select_kind(select_kind), .byte_out(bo[1]), .byte_stb(stb[1]),
    .mode_dec_or_en(md[1]), .mode_kind(mk[1]), .busy(bz[1]), .frame_done(fd[1]), .err_kind(ek[1]));

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pop(int d);
    int v = -2;
    if (d == 0 && q0.size() > 0) v = q0.pop_front();
    if (d == 1 && q1.size() > 0) v = q1.pop_front();
    return v;
  endfunction

  function automatic int nbits(bit dec, bit [1:0] k);
    if (dec) return k == 0 ? 12 : k == 1 ? 24 : 30;
    return k == 0 ? 8 : k == 1 ? 16 : 20;
  endfunction

  // Reference: keep the low N bits, pad to whole bytes at the bottom, read bytes MSB-first.
  function automatic void push_frame(bit dec, bit [1:0] k, bit [29:0] w);
    int n = nbits(dec, k);
    int nb = (n + 7) / 8;
    longint v = (longint'(w) & ((64'd1 << n) - 1)) << (nb * 8 - n);
    for (int i = 0; i < nb; i++) begin
      q0.push_back(int'((v >> (8 * (nb - 1 - i))) & 255));
      q1.push_back(int'((v >> (8 * (nb - 1 - i))) & 255));
    end
    q0.push_back(-1);
    q1.push_back(-1);
  endfunction

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst) begin
        ps[d] = 0; in_frame[d] = 0; run[d] = 0; gap[d] = 0;
      end else begin
        if (stb[d]) begin
          if (!ps[d] || run[d] == 2) begin
            if (!ps[d] && in_frame[d]) chk("gap_len", gap[d], d == 0 ? 2 : 0);
            chk("byte", int'(bo[d]), pop(d));
            chk("mode_kind", int'(mk[d]), int'(exp_kind));
            chk("mode_dec", int'(md[d]), int'(exp_dec));
            run[d] = 1; in_frame[d] = 1; cur[d] = int'(bo[d]);
          end else begin
            run[d]++;
            chk("byte_hold", int'(bo[d]), cur[d]);
          end
          gap[d] = 0;
        end else begin
          if (ps[d]) chk("stb_len", run[d], 2);
          if (in_frame[d]) gap[d]++;
        end
        if (fd[d]) begin
          chk("frame_end", pop(d), -1);
          chk("done_after_stb", int'(ps[d]), 1);
          in_frame[d] = 0;
        end
        chk("ready_vs_busy", int'(wr[d]), int'(!bz[d]));
        if (ek[d]) seen_err[d]++;
        ps[d] = stb[d];
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (wr[0] && wr[1]) return;
    end
    chk("idle_timeout", 0, 1);
  endtask

  task automatic send(bit dec, bit [1:0] k, bit [29:0] w);
    wait_idle();
    word_in = w; dec_or_en = dec; select_kind = k; word_valid = 1;
    if (k == 2) exp_err++;
    else begin
      push_frame(dec, k, w);
      exp_dec = dec; exp_kind = k;
    end
    @(negedge clk);
    word_valid = 0;
    word_in = $urandom; dec_or_en = 1'($urandom); select_kind = 2'($urandom);
  endtask

  initial begin
    bit [1:0] k;
    int target;
    repeat (3) @(negedge clk);
    chk("rst_stb", int'(stb[0]), 0);
    chk("rst_busy", int'(bz[0]), 0);
    chk("rst_byte", int'(bo[0]), 0);
    chk("rst_mode", int'({md[0], mk[0]}), 0);
    rst = 1;
    @(negedge clk);
    chk("rst_ready", int'(wr[0]), 1);
    chk("rst_done", int'(fd[0]), 0);
    send(0, 0, 30'h000000A5);
    chk("lat_stb1", int'(stb[0]), 1);
    chk("lat_byte", int'(bo[0]), 8'hA5);
    @(negedge clk);
    chk("lat_stb2", int'(stb[0]), 1);
    @(negedge clk);
    chk("lat_done", int'(fd[0]), 1);
    chk("lat_stb_off", int'(stb[0]), 0);
    @(negedge clk);
    chk("lat_ready", int'(wr[0]), 1);
    send(0, 3, 30'h000ABCDE);
    send(1, 3, 30'h2ABCDEF1);
    chk("dec3_busy", int'(bz[0]), 1);
    send(1, 0, 30'h3FFFFABC);
    for (int i = 0; i < 4; i++) begin
      chk("nogap_stb", int'(stb[1]), 1);
      chk("nogap_byte", int'(bo[1]), i < 2 ? 8'hAB : 8'hC0);
      @(negedge clk);
    end
    chk("nogap_done", int'(fd[1]), 1);
    send(0, 2, 30'h12345);
    chk("err_pulse", int'(ek[0]), 1);
    chk("err_busy", int'(bz[0]), 0);
    chk("err_ready", int'(wr[0]), 1);
    chk("err_stb", int'(stb[0]), 0);
    @(negedge clk);
    chk("err_once", int'(ek[0]), 0);
    chk("err_stb2", int'(stb[0]), 0);
    send(0, 1, 30'h1234);
    send(1, 1, 30'h0A1B2C3D);
    target = 8'h2C;
    for (int i = 0; i < 40 && !(stb[0] && int'(bo[0]) == target); i++) @(negedge clk);
    chk("rst_reached_byte2", int'(stb[0] && int'(bo[0]) == target), 1);
    #1 rst = 0;
    #1;
    chk("async_stb", int'(stb[0] | stb[1]), 0);
    chk("async_busy", int'(bz[0] | bz[1]), 0);
    chk("async_done", int'(fd[0] | fd[1]), 0);
    q0.delete(); q1.delete();
    @(negedge clk);
    #1 rst = 1;
    send(0, 0, 30'h5A);
    chk("post_rst_byte", int'(bo[0]), 8'h5A);
    for (int i = 0; i < 40; i++) begin
      k = ($urandom_range(0, 9) == 0) ? 2'd2 : 2'($urandom_range(0, 2));
      if (k == 2'd2 && $urandom_range(0, 1) == 0) k = 2'd3;
      send(1'($urandom), k, 30'($urandom));
    end
    wait_idle();
    repeat (3) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("err_count0", seen_err[0], exp_err);
    chk("err_count1", seen_err[1], exp_err);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
